delay_sum_engine: RTL and testbench

- Downstream stage of the beamformer delay lookup.
- Consumes the per-mic steering delays (lookup_delays) and the per-mic PCM sample stream.
- Stores each mic's history in a circular delay line, then reads each mic at its delay.
- Sums all NUM_MICS delayed samples into one full-precision beam sample per input frame.
- Mics are processed serially, one per clock, through a single accumulator.

---
 rtl/beam_pkg.sv | 36 +++
 rtl/delay_sum_engine_if.sv | 25 ++
 rtl/delay_line_ram.sv | 27 ++
 rtl/delay_sum_engine.sv | 200 ++++++++++++++++++++
 tb/tb_delay_sum_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/beam_pkg.sv
// Shared definitions for the delay-and-sum beamformer back end:
// sizing constants, sample/delay vector types and the engine state encoding.
package beam_pkg;

    localparam int BIT_WIDTH         = 24;
    localparam int NUM_MICS          = 9;
    localparam int BEAM_SR_SIZE_LOG2 = 10;
    localparam int SUM_WIDTH         = 28;

    localparam int DEPTH     = 2**BEAM_SR_SIZE_LOG2;
    localparam int MIC_IDX_W = $clog2(NUM_MICS);
    localparam int FILL_W    = BEAM_SR_SIZE_LOG2 + 1;

    // Fill count saturates once the whole delay line holds real history.
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    typedef logic signed [BIT_WIDTH-1:0]         sample_t;
    typedef logic        [BEAM_SR_SIZE_LOG2-1:0] delay_t;
    typedef logic signed [SUM_WIDTH-1:0]         sum_t;
    typedef sample_t [NUM_MICS-1:0]              sample_vec_t;
    typedef delay_t  [NUM_MICS-1:0]              delay_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        OUT
    } state_t;

    // Widen one PCM sample to accumulator width, preserving its sign.
    function automatic sum_t sign_extend(input sample_t s);
        return {{(SUM_WIDTH-BIT_WIDTH){s[BIT_WIDTH-1]}}, s};
    endfunction

endpackage

// File: rtl/delay_sum_engine_if.sv
// Frame/delay input bus and beam output bus of the delay-and-sum engine.
// The engine is the slave; whatever produces frames and delays is the master.
interface delay_sum_engine_if;
    import beam_pkg::*;

    logic        pcm_valid;
    sample_vec_t pcm_data_in;
    logic        delays_load;
    delay_vec_t  lookup_delays;
    sum_t        sum_data;
    logic        sum_valid;
    logic        busy;
    logic        overrun;

    modport master (
        output pcm_valid, pcm_data_in, delays_load, lookup_delays,
        input  sum_data, sum_valid, busy, overrun
    );

    modport slave (
        input  pcm_valid, pcm_data_in, delays_load, lookup_delays,
        output sum_data, sum_valid, busy, overrun
    );

endinterface

// File: rtl/delay_line_ram.sv
// One microphone's circular history: simple dual-port RAM with a registered
// read port; a read of the address being written returns the new data.
module delay_line_ram
    import beam_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  delay_t  waddr,
    input  sample_t wdata,
    input  delay_t  raddr,
    output sample_t rdata
);

    sample_t mem [DEPTH];
    sample_t rdata_q;

    // Write port plus write-first registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/delay_sum_engine.sv
// Delay-and-sum engine: stores each mic's samples in its own delay line,
// then walks the mics one per clock, summing each at its steering delay.
module delay_sum_engine
    import beam_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    delay_sum_engine_if.slave  bus
);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    state_t              state_q,       state_d;
    logic                busy_q,        busy_d;
    logic                overrun_q,     overrun_d;
    sum_t                sum_data_q,    sum_data_d;
    logic                sum_valid_q,   sum_valid_d;
    sample_vec_t         pcm_q,         pcm_d;
    delay_t              wr_ptr_q,      wr_ptr_d;
    logic [FILL_W-1:0]   fill_q,        fill_d;
    delay_vec_t          active_q,      active_d;
    delay_vec_t          pending_q,     pending_d;
    logic                pending_vld_q, pending_vld_d;
    sum_t                acc_q,         acc_d;
    logic [MIC_IDX_W-1:0] mic_q,        mic_d;
    logic                rd_vld_q,      rd_vld_d;
    logic                rd_keep_q,     rd_keep_d;
    logic [MIC_IDX_W-1:0] rd_mic_q,     rd_mic_d;

    logic    ram_we;
    sample_t rd_data [NUM_MICS];
    sample_t rd_sel;
    delay_t  cur_delay;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign ram_we = (state_q == WRITE);

    generate
        for (genvar i = 0; i < NUM_MICS; i++) begin : g_mic
            delay_line_ram u_ram (
                .clk   (clk),
                .we    (ram_we),
                .waddr (wr_ptr_q),
                .wdata (pcm_q[i]),
                .raddr (wr_ptr_q - active_q[i]),
                .rdata (rd_data[i])
            );
        end
    endgenerate

    // Pick the delay of the mic being issued and the word of the mic returning.
    always_comb begin
        rd_sel    = '0;
        cur_delay = '0;
        for (int i = 0; i < NUM_MICS; i++) begin
            if (rd_mic_q == MIC_IDX_W'(i)) rd_sel    = rd_data[i];
            if (mic_q    == MIC_IDX_W'(i)) cur_delay = active_q[i];
        end
    end

    // Frame sequencing, accumulation, delay-set management and overrun tracking.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        overrun_d     = overrun_q;
        sum_data_d    = sum_data_q;
        sum_valid_d   = 1'b0;
        pcm_d         = pcm_q;
        wr_ptr_d      = wr_ptr_q;
        fill_d        = fill_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        acc_d         = acc_q;
        mic_d         = mic_q;
        rd_vld_d      = 1'b0;
        rd_keep_d     = 1'b0;
        rd_mic_d      = rd_mic_q;

        if (bus.delays_load) begin
            if ((state_q == IDLE) && !bus.pcm_valid) begin
                active_d = bus.lookup_delays;
            end else begin
                pending_d     = bus.lookup_delays;
                pending_vld_d = 1'b1;
            end
        end

        if (bus.pcm_valid && busy_q) begin
            overrun_d = 1'b1;
        end

        if (rd_vld_q && rd_keep_q) begin
            acc_d = acc_q + sign_extend(rd_sel);
        end

        case (state_q)
            IDLE: begin
                if (bus.pcm_valid) begin
                    pcm_d   = bus.pcm_data_in;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d   = '0;
                mic_d   = '0;
                state_d = READ;
            end
            READ: begin
                rd_vld_d  = 1'b1;
                rd_mic_d  = mic_q;
                rd_keep_d = ({1'b0, cur_delay} <= fill_q);
                if (mic_q == MIC_IDX_W'(NUM_MICS-1)) begin
                    state_d = DRAIN;
                end else begin
                    mic_d = mic_q + MIC_IDX_W'(1);
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                sum_data_d  = acc_q;
                sum_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + delay_t'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (bus.delays_load) begin
                    active_d = bus.lookup_delays;
                end else if (pending_vld_q) begin
                    active_d = pending_q;
                end
                pending_vld_d = 1'b0;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame and restarts history.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            sum_data_q    <= '0;
            sum_valid_q   <= 1'b0;
            pcm_q         <= '0;
            wr_ptr_q      <= '0;
            fill_q        <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            acc_q         <= '0;
            mic_q         <= '0;
            rd_vld_q      <= 1'b0;
            rd_keep_q     <= 1'b0;
            rd_mic_q      <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            sum_data_q    <= sum_data_d;
            sum_valid_q   <= sum_valid_d;
            pcm_q         <= pcm_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            acc_q         <= acc_d;
            mic_q         <= mic_d;
            rd_vld_q      <= rd_vld_d;
            rd_keep_q     <= rd_keep_d;
            rd_mic_q      <= rd_mic_d;
        end
    end

    assign bus.sum_data  = sum_data_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_delay_sum_engine.sv
// Bench for delay_sum_engine: fixed vector table, hand-written corner
// sequences and randomized frames against a history-based reference model.
module tb_delay_sum_engine;
    import beam_pkg::*;

    localparam int LATENCY = NUM_MICS + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    delay_sum_engine_if bus();

    delay_sum_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: every accepted frame's samples since reset, per mic.
    int         hist [NUM_MICS][$];
    delay_vec_t model_delays;

    typedef struct {
        bit          rst;
        bit          load;
        delay_vec_t  delays;
        sample_vec_t samples;
        longint      exp_sum;
    } vec_row_t;

    vec_row_t table_rows [12];

    // Compare one observed value with the bench's expectation.
    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic sample_vec_t all_samples(input int v);
        sample_vec_t s;
        for (int i = 0; i < NUM_MICS; i++) s[i] = sample_t'(v);
        return s;
    endfunction

    function automatic delay_vec_t one_delay(input int mic, input int d);
        delay_vec_t dv;
        dv = '0;
        dv[mic] = delay_t'(d);
        return dv;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < NUM_MICS; m++) hist[m].delete();
        model_delays = '0;
    endfunction

    // Beam sample = sum over mics of the sample 'delay' frames back, 0 if none yet.
    function automatic longint model_frame(input sample_vec_t s);
        longint acc;
        int     n;
        int     d;
        acc = 0;
        for (int m = 0; m < NUM_MICS; m++) begin
            hist[m].push_back(int'($signed(s[m])));
            n = hist[m].size() - 1;
            d = int'(model_delays[m]);
            if (d <= n) acc += longint'(hist[m][n-d]);
        end
        return acc;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n           = 1'b0;
        bus.pcm_valid   = 1'b0;
        bus.delays_load = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    task automatic load_delays(input delay_vec_t d);
        bus.lookup_delays = d;
        bus.delays_load   = 1'b1;
        @(negedge clk);
        bus.delays_load   = 1'b0;
        model_delays      = d;
    endtask

    // Watch negedges for sum_valid; 'elapsed' is the index of the current negedge.
    task automatic wait_sum(input int elapsed, output int lat, output longint sum);
        lat = -1;
        sum = 0;
        for (int i = 0; i < 31; i++) begin
            if (bus.sum_valid) begin
                lat = elapsed + i;
                sum = longint'(bus.sum_data);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Present one frame (optionally with a coincident delay load) and await its sum.
    task automatic apply_stimulus(input sample_vec_t s, input bit coload, input delay_vec_t cod,
                                  output int lat, output longint sum);
        bus.pcm_data_in   = s;
        bus.pcm_valid     = 1'b1;
        bus.lookup_delays = cod;
        bus.delays_load   = coload;
        @(negedge clk);
        bus.pcm_valid     = 1'b0;
        bus.delays_load   = 1'b0;
        wait_sum(1, lat, sum);
    endtask

    task automatic run_frame(input string name, input sample_vec_t s, input longint exp_sum);
        int     lat;
        longint sum;
        apply_stimulus(s, 1'b0, '0, lat, sum);
        check_output({name, " latency"}, lat, LATENCY);
        check_output({name, " sum"}, sum, exp_sum);
    endtask

    initial begin
        int          lat;
        longint      sum;
        int          seen_valid;
        int          seen_busy;
        sample_vec_t s;
        delay_vec_t  d;
        longint      exp_sum;
        bit          coload;

        bus.pcm_valid     = 1'b0;
        bus.pcm_data_in   = '0;
        bus.delays_load   = 1'b0;
        bus.lookup_delays = '0;
        model_reset();

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_output("reset sum_data", longint'(bus.sum_data), 0);
        check_output("reset sum_valid", longint'(bus.sum_valid), 0);
        check_output("reset busy", longint'(bus.busy), 0);
        check_output("reset overrun", longint'(bus.overrun), 0);
        seen_valid = 0;
        seen_busy  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sum_valid) seen_valid++;
            if (bus.busy) seen_busy++;
        end
        check_output("idle sum_valid count", seen_valid, 0);
        check_output("idle busy count", seen_busy, 0);

        // Vector table: zero-delay frames, then the delayed impulse with fill masking.
        for (int i = 0; i < 5; i++) begin
            table_rows[i] = '{rst: (i == 0), load: (i == 0), delays: '0,
                              samples: all_samples(1000), exp_sum: 9000};
        end
        for (int i = 5; i < 12; i++) begin
            table_rows[i] = '{rst: (i == 5), load: (i == 5), delays: one_delay(3, 5),
                              samples: all_samples(0), exp_sum: 0};
        end
        table_rows[5].samples[3] = sample_t'(-8388608);
        table_rows[10].exp_sum   = -8388608;

        for (int i = 0; i < 12; i++) begin
            if (table_rows[i].rst) do_reset(3);
            if (table_rows[i].load) load_delays(table_rows[i].delays);
            run_frame($sformatf("table row %0d", i), table_rows[i].samples, table_rows[i].exp_sum);
            check_output($sformatf("table row %0d overrun", i), longint'(bus.overrun), 0);
        end

        // Maximum delay on mic0, run past the write-pointer wrap.
        do_reset(3);
        load_delays(one_delay(0, DEPTH-1));
        for (int k = 0; k < 1100; k++) begin
            s    = all_samples(0);
            s[0] = sample_t'(k);
            run_frame($sformatf("wrap frame %0d", k), s, (k >= DEPTH-1) ? longint'(k - (DEPTH-1)) : 0);
        end

        // Overrun with a delay load arriving while busy.
        do_reset(3);
        bus.pcm_data_in = all_samples(7);
        bus.pcm_valid   = 1'b1;
        @(negedge clk);
        bus.pcm_valid   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("busy mid-frame", longint'(bus.busy), 1);
        bus.pcm_data_in   = all_samples(99);
        bus.pcm_valid     = 1'b1;
        bus.lookup_delays = one_delay(0, 1);
        bus.delays_load   = 1'b1;
        @(negedge clk);
        bus.pcm_valid     = 1'b0;
        bus.delays_load   = 1'b0;
        check_output("overrun set", longint'(bus.overrun), 1);
        wait_sum(5, lat, sum);
        check_output("overrun frame latency", lat, LATENCY);
        check_output("overrun frame sum old delays", sum, 63);
        run_frame("frame after pending load", all_samples(5), 47);
        check_output("overrun sticky", longint'(bus.overrun), 1);

        // A frame offered during OUT is dropped and never enters history.
        bus.pcm_data_in = all_samples(1);
        bus.pcm_valid   = 1'b1;
        @(negedge clk);
        bus.pcm_valid   = 1'b0;
        repeat (11) @(negedge clk);
        check_output("busy in OUT cycle", longint'(bus.busy), 1);
        bus.pcm_data_in = all_samples(50);
        bus.pcm_valid   = 1'b1;
        @(negedge clk);
        bus.pcm_valid   = 1'b0;
        wait_sum(13, lat, sum);
        check_output("OUT-collision frame latency", lat, LATENCY);
        check_output("OUT-collision frame sum", sum, 13);
        @(negedge clk);
        wait_sum(0, lat, sum);
        check_output("dropped OUT-cycle frame produces no sum", lat, -1);
        run_frame("history skips dropped frame", all_samples(2), 17);

        // Reset asserted in the middle of the read phase.
        do_reset(3);
        bus.pcm_data_in = all_samples(123);
        bus.pcm_valid   = 1'b1;
        @(negedge clk);
        bus.pcm_valid   = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("mid-frame reset busy", longint'(bus.busy), 0);
        check_output("mid-frame reset sum_valid", longint'(bus.sum_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_sum(0, lat, sum);
        check_output("aborted frame produces no sum", lat, -1);
        run_frame("post-reset all -1", all_samples(-1), -9);

        // Randomized frames and delay sets against the reference model.
        do_reset(3);
        for (int f = 0; f < 80; f++) begin
            if ((f == 0) || ($urandom_range(0, 3) == 0)) begin
                for (int m = 0; m < NUM_MICS; m++) d[m] = delay_t'($urandom_range(0, 12));
                load_delays(d);
            end
            for (int m = 0; m < NUM_MICS; m++) s[m] = sample_t'($urandom());
            coload = ($urandom_range(0, 4) == 0);
            for (int m = 0; m < NUM_MICS; m++) d[m] = delay_t'($urandom_range(0, 12));
            exp_sum = model_frame(s);
            apply_stimulus(s, coload, d, lat, sum);
            if (coload) model_delays = d;
            check_output($sformatf("random frame %0d latency", f), lat, LATENCY);
            check_output($sformatf("random frame %0d sum", f), sum, exp_sum);
        end
        check_output("random overrun clear", longint'(bus.overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
